// File: rtl/lcd_enable_pulse_gen.sv
// HD44780-style write sequencer timed by rising edges of the clock divider's slow wave.
// Define LCD_TICK_SYNC_EN to put a 2-flop synchronizer on div_clk when the divider runs in another clock domain.
module lcd_enable_pulse_gen #(
    parameter int SETUP_TICKS     = 1,
    parameter int E_HIGH_TICKS    = 1,
    parameter int HOLD_TICKS      = 1,
    parameter int WAIT_TICKS      = 2,
    parameter int LONG_WAIT_TICKS = 38
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       div_clk,
    input  logic       wr_req,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_db
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_TICKS = max2(max2(max2(SETUP_TICKS, E_HIGH_TICKS),
                                         max2(HOLD_TICKS, WAIT_TICKS)),
                                    LONG_WAIT_TICKS);
    localparam int CW = $clog2(MAX_TICKS + 1);

    localparam logic [CW-1:0] SETUP_LAST     = CW'(SETUP_TICKS - 1);
    localparam logic [CW-1:0] E_HIGH_LAST    = CW'(E_HIGH_TICKS - 1);
    localparam logic [CW-1:0] HOLD_LAST      = CW'(HOLD_TICKS - 1);
    localparam logic [CW-1:0] WAIT_LAST      = CW'(WAIT_TICKS - 1);
    localparam logic [CW-1:0] LONG_WAIT_LAST = CW'(LONG_WAIT_TICKS - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_E_HIGH = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_WAIT   = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_bump;
    logic [CW-1:0] wait_last;
    logic          long_cmd;
    logic          div_q;
    logic          edge_src;
    logic          tick_armed;
    logic          tick;

`ifdef LCD_TICK_SYNC_EN
    logic div_s1;
    logic div_s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_s1 <= 1'b0;
            div_s2 <= 1'b0;
        end else begin
            div_s1 <= div_clk;
            div_s2 <= div_s1;
        end
    end

    assign edge_src = div_s2;
`else
    assign edge_src = div_clk;
`endif

    // tick_armed suppresses a false edge in the first cycle after reset when div_clk is already high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q      <= 1'b0;
            tick_armed <= 1'b0;
        end else begin
            div_q      <= edge_src;
            tick_armed <= 1'b1;
        end
    end

    assign tick = tick_armed & edge_src & ~div_q;

    always_comb begin
        cnt_bump  = (cnt == '1) ? cnt : cnt + 1'b1;
        wait_last = long_cmd ? LONG_WAIT_LAST : WAIT_LAST;
    end

    assign busy   = (state != ST_IDLE);
    assign lcd_rw = 1'b0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            long_cmd <= 1'b0;
            done     <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_e    <= 1'b0;
            lcd_db   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (wr_req) begin
                        lcd_rs   <= wr_rs;
                        lcd_db   <= wr_data;
                        long_cmd <= ~wr_rs & ((wr_data[7:1] == 7'b0000001) | (wr_data == 8'h01));
                        state    <= ST_SETUP;
                        cnt      <= '0;
                    end
                end
                ST_SETUP: begin
                    if (tick) begin
                        if (cnt == SETUP_LAST) begin
                            state <= ST_E_HIGH;
                            lcd_e <= 1'b1;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt_bump;
                        end
                    end
                end
                ST_E_HIGH: begin
                    if (tick) begin
                        if (cnt == E_HIGH_LAST) begin
                            state <= ST_HOLD;
                            lcd_e <= 1'b0;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt_bump;
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        if (cnt == HOLD_LAST) begin
                            state <= ST_WAIT;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt_bump;
                        end
                    end
                end
                ST_WAIT: begin
                    if (tick) begin
                        if (cnt == wait_last) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt_bump;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    lcd_e <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_enable_pulse_gen.sv
// Directed bench for lcd_enable_pulse_gen: a scoreboard of expected transactions checked on each done pulse.
module tb_lcd_enable_pulse_gen;

    logic       clk     = 1'b0;
    logic       rst     = 1'b0;
    logic       div_clk = 1'b0;
    logic       wr_req  = 1'b0;
    logic       wr_rs   = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       busy;
    logic       done;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_db;

    int asserts = 0;
    int fails   = 0;

    lcd_enable_pulse_gen #(
        .SETUP_TICKS    (1),
        .E_HIGH_TICKS   (1),
        .HOLD_TICKS     (1),
        .WAIT_TICKS     (2),
        .LONG_WAIT_TICKS(38)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .div_clk(div_clk),
        .wr_req (wr_req),
        .wr_rs  (wr_rs),
        .wr_data(wr_data),
        .busy   (busy),
        .done   (done),
        .lcd_rs (lcd_rs),
        .lcd_rw (lcd_rw),
        .lcd_e  (lcd_e),
        .lcd_db (lcd_db)
    );

    always #5 clk = ~clk;

    // divider: full 2048-clk period at first, shortened later to keep the run short
    int unsigned half = 1024;
    int unsigned dcnt = 0;
    always @(posedge clk) begin
        if (dcnt >= half - 1) begin
            dcnt    <= 0;
            div_clk <= ~div_clk;
        end else begin
            dcnt <= dcnt + 1;
        end
    end

    logic        div_prev   = 1'b0;
    logic        last_tick  = 1'b0;
    int unsigned tick_total = 0;
    always @(posedge clk) begin
        div_prev  <= div_clk;
        last_tick <= div_clk & ~div_prev;
        if (div_clk && !div_prev) tick_total <= tick_total + 1;
    end

    typedef struct packed {
        logic        rs;
        logic [7:0]  db;
        logic [31:0] ticks;
        logic [31:0] start;
    } txn_t;

    txn_t        sb[$];
    int unsigned done_cnt = 0;
    logic        done_d   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        asserts++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        txn_t t;
        if (done === 1'b1) begin
            done_cnt++;
            check("done_single", 32'(done_d), 32'd0);
            if (sb.size() == 0) begin
                check("done_unexpected", 32'd1, 32'd0);
            end else begin
                t = sb.pop_front();
                check("done_ticks", tick_total - t.start, t.ticks);
                check("done_on_tick", 32'(last_tick), 32'd1);
                check("done_rs", 32'(lcd_rs), 32'(t.rs));
                check("done_db", 32'(lcd_db), 32'(t.db));
                check("done_busy", 32'(busy), 32'd0);
            end
        end
        done_d <= done;
    end

    task automatic push_txn(input logic rs, input logic [7:0] d, input int unsigned nt);
        txn_t t;
        t.rs    = rs;
        t.db    = d;
        t.ticks = nt;
        t.start = tick_total;
        sb.push_back(t);
    endtask

    task automatic send(input logic rs, input logic [7:0] d, input int unsigned nt);
        @(negedge clk); #1;
        wr_req  = 1'b1;
        wr_rs   = rs;
        wr_data = d;
        @(negedge clk); #1;
        wr_req = 1'b0;
        check("acc_busy", 32'(busy), 32'd1);
        check("acc_rs", 32'(lcd_rs), 32'(rs));
        check("acc_db", 32'(lcd_db), 32'(d));
        push_txn(rs, d, nt);
    endtask

    task automatic wait_done(input int unsigned target, input int unsigned budget);
        int unsigned n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (done_cnt < target) check("done_timeout", done_cnt, target);
    endtask

    task automatic wait_e_high(input int unsigned budget);
        int unsigned n = 0;
        while (lcd_e !== 1'b1 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (lcd_e !== 1'b1) check("e_rise_timeout", 32'(lcd_e), 32'd1);
    endtask

    task automatic measure_e(input int unsigned exp, input int unsigned budget);
        int unsigned n = 0;
        wait_e_high(budget);
        if (lcd_e === 1'b1) begin
            do begin
                n++;
                @(negedge clk); #1;
            end while (lcd_e === 1'b1 && n < budget);
            check("e_width", n, exp);
        end
    endtask

    initial begin
        int unsigned base;

        repeat (5) begin
            @(negedge clk);
            wr_req  = 1'($urandom);
            wr_rs   = 1'($urandom);
            wr_data = 8'($urandom);
            #1;
            check("rst_outputs", {26'd0, busy, done, lcd_e, lcd_rs, lcd_rw, 1'b0}, 32'd0);
            check("rst_db", 32'(lcd_db), 32'd0);
        end
        wr_req = 1'b0;
        @(negedge clk); #1;
        rst = 1'b1;

        send(1'b1, 8'h41, 5);
        measure_e(2048, 5000);
        wait_done(1, 12000);
        check("rw_low", 32'(lcd_rw), 32'd0);

        half = 128;
        send(1'b0, 8'h01, 41);
        wait_done(2, 20000);
        send(1'b0, 8'h28, 5);
        measure_e(256, 1000);
        wait_done(3, 3000);
        send(1'b0, 8'h03, 41);
        wait_done(4, 20000);
        send(1'b1, 8'h01, 5);
        wait_done(5, 3000);

        send(1'b1, 8'h41, 5);
        wait_e_high(1000);
        wr_req  = 1'b1;
        wr_rs   = 1'b0;
        wr_data = 8'h55;
        @(negedge clk); #1;
        wr_req = 1'b0;
        check("ign_db", 32'(lcd_db), 32'h41);
        check("ign_rs", 32'(lcd_rs), 32'd1);
        wait_done(6, 3000);
        repeat (600) @(negedge clk);
        #1;
        check("ign_done_cnt", done_cnt, 32'd6);
        check("ign_sb_empty", sb.size(), 32'd0);

        send(1'b0, 8'h28, 5);
        wait_e_high(1000);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        check("arst_e", 32'(lcd_e), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        sb.delete();
        repeat (600) @(negedge clk);
        #1;
        check("arst_no_done", done_cnt, 32'd6);
        check("arst_db", 32'(lcd_db), 32'd0);
        rst = 1'b1;
        send(1'b1, 8'h42, 5);
        wait_done(7, 3000);

        base = done_cnt;
        @(negedge clk); #1;
        wr_req  = 1'b1;
        wr_rs   = 1'b0;
        wr_data = 8'h30;
        @(negedge clk); #1;
        check("b2b_busy0", 32'(busy), 32'd1);
        push_txn(1'b0, 8'h30, 5);
        for (int i = 0; i < 3; i++) begin
            wait_done(base + i + 1, 3000);
            check("b2b_gap", 32'(busy), 32'd0);
            if (i == 2) wr_req = 1'b0;
            @(negedge clk); #1;
            if (i < 2) begin
                check("b2b_busy", 32'(busy), 32'd1);
                push_txn(1'b0, 8'h30, 5);
            end else begin
                check("b2b_end_idle", 32'(busy), 32'd0);
            end
        end
        check("final_sb_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
